// File: rtl/flash_fetch_scheduler.sv
// rtl/flash_fetch_scheduler.sv - arbitrates video/audio refill bursts onto the shared SPI flash reader
module flash_fetch_scheduler #(
  parameter int                ADDR_W         = 24,
  parameter int                LEN_W          = 12,
  parameter logic [ADDR_W-1:0] VID_BASE       = 24'h000000,
  parameter logic [ADDR_W-1:0] VID_END        = 24'h100000,
  parameter int                VID_BURST      = 80,
  parameter logic [ADDR_W-1:0] AUD_BASE       = 24'h100000,
  parameter logic [ADDR_W-1:0] AUD_END        = 24'h180000,
  parameter int                AUD_BURST      = 64,
  parameter int                MAX_AUD_CONSEC = 2,
  parameter int                TIMEOUT        = 4096
) (
  input  logic              CLK_40,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              vid_req,
  input  logic              aud_req,
  input  logic              rd_done,
  output logic              rd_start,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [LEN_W-1:0]  rd_len,
  output logic              rd_owner,
  output logic              vid_grant,
  output logic              aud_grant,
  output logic              vid_done,
  output logic              aud_done,
  output logic              timeout,
  output logic              busy
);

  localparam int SW    = $clog2(MAX_AUD_CONSEC + 2);
  localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] vid_ptr_q, aud_ptr_q;
  logic [SW-1:0]     starve_cnt_q;
  logic [TMO_W-1:0]  tmo_cnt_q;
  logic              rd_start_q, rd_owner_q, vid_grant_q, aud_grant_q;
  logic              vid_done_q, aud_done_q, timeout_q, busy_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic [LEN_W-1:0]  rd_len_q;

  logic [ADDR_W:0]   vid_next_d, aud_next_d;
  logic [ADDR_W-1:0] vid_ptr_d, aud_ptr_d;
  logic              aud_win_d;

  // Sum is one bit wider so a pointer near the top of the address space cannot alias past END.
  always_comb begin
    vid_next_d = {1'b0, vid_ptr_q} + (ADDR_W+1)'(VID_BURST);
    aud_next_d = {1'b0, aud_ptr_q} + (ADDR_W+1)'(AUD_BURST);
    vid_ptr_d  = (vid_next_d >= {1'b0, VID_END}) ? VID_BASE : vid_next_d[ADDR_W-1:0];
    aud_ptr_d  = (aud_next_d >= {1'b0, AUD_END}) ? AUD_BASE : aud_next_d[ADDR_W-1:0];
    aud_win_d  = aud_req && !(vid_req && (starve_cnt_q == SW'(MAX_AUD_CONSEC)));
  end

  always_ff @(posedge CLK_40) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      vid_ptr_q    <= VID_BASE;
      aud_ptr_q    <= AUD_BASE;
      starve_cnt_q <= '0;
      tmo_cnt_q    <= '0;
      rd_start_q   <= 1'b0;
      rd_owner_q   <= 1'b0;
      vid_grant_q  <= 1'b0;
      aud_grant_q  <= 1'b0;
      vid_done_q   <= 1'b0;
      aud_done_q   <= 1'b0;
      timeout_q    <= 1'b0;
      busy_q       <= 1'b0;
      rd_addr_q    <= '0;
      rd_len_q     <= '0;
    end else begin
      rd_start_q  <= 1'b0;
      vid_grant_q <= 1'b0;
      aud_grant_q <= 1'b0;
      vid_done_q  <= 1'b0;
      aud_done_q  <= 1'b0;
      timeout_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (enable && (vid_req || aud_req)) begin
            state_q     <= S_ISSUE;
            busy_q      <= 1'b1;
            rd_start_q  <= 1'b1;
            rd_owner_q  <= aud_win_d;
            aud_grant_q <= aud_win_d;
            vid_grant_q <= !aud_win_d;
            rd_addr_q   <= aud_win_d ? aud_ptr_q : vid_ptr_q;
            rd_len_q    <= aud_win_d ? LEN_W'(AUD_BURST) : LEN_W'(VID_BURST);
            if (aud_win_d && vid_req) begin
              if (starve_cnt_q != SW'(MAX_AUD_CONSEC)) starve_cnt_q <= starve_cnt_q + 1'b1;
            end else begin
              starve_cnt_q <= '0;
            end
          end
        end
        S_ISSUE: begin
          state_q   <= S_WAIT;
          tmo_cnt_q <= '0;
        end
        S_WAIT: begin
          if (rd_done) begin
            state_q   <= S_IDLE;
            busy_q    <= 1'b0;
            tmo_cnt_q <= '0;
            if (rd_owner_q) begin
              aud_done_q <= 1'b1;
              aud_ptr_q  <= aud_ptr_d;
            end else begin
              vid_done_q <= 1'b1;
              vid_ptr_q  <= vid_ptr_d;
            end
          end else if (tmo_cnt_q == TMO_W'(TIMEOUT - 1)) begin
            state_q   <= S_IDLE;
            busy_q    <= 1'b0;
            tmo_cnt_q <= '0;
            timeout_q <= 1'b1;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rd_start  = rd_start_q;
  assign rd_addr   = rd_addr_q;
  assign rd_len    = rd_len_q;
  assign rd_owner  = rd_owner_q;
  assign vid_grant = vid_grant_q;
  assign aud_grant = aud_grant_q;
  assign vid_done  = vid_done_q;
  assign aud_done  = aud_done_q;
  assign timeout   = timeout_q;
  assign busy      = busy_q;

endmodule
